dut_pipe_top: RTL and testbench
===============================

Name: dut_pipe_top

Overview:
- Parametrised successor to the single-stage two-operand capture block.
- Accepts NUM_CH lanes of paired operands (a, b) through a valid/ready handshake.
- Applies a per-beat selectable lane operation and carries the results through a DEPTH-stage elastic register pipeline with full back-pressure.
- Counts delivered beats. Sits between the stimulus/driver interface and downstream checkers in the test top.

Parameters:
- NUM_CH, 2, number of independent operand lanes.
- WIDTH, 8, bits per operand per lane.
- DEPTH, 3, number of pipeline register stages; legal range 1..8.
- CNT_W, 16, width of the delivered-beat counter.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid_i  input  1  operand beat valid.
- in_ready_o  output  1  block can accept a beat this cycle.
- mode_i  input  2  lane operation (mode_e), sampled with the beat.
- a_i  input  NUM_CH*WIDTH  packed operand A; lane k at [k*WIDTH +: WIDTH].
- b_i  input  NUM_CH*WIDTH  packed operand B, same packing.
- out_valid_o  output  1  result beat valid.
- out_ready_i  input  1  downstream accepts the result.
- out_data_o  output  NUM_CH*(WIDTH+1)  packed results; lane k at [k*(WIDTH+1) +: WIDTH+1].
- out_mode_o  output  2  mode the beat was issued with.
- count_o  output  CNT_W  delivered-beat count, saturating.

Behaviour:
- Reset: synchronous, active-high, on the clk edge with rst=1.
  - Clears all stage valid bits, stage data, stage mode and count_o to 0.
  - During and after reset: out_valid_o=0, out_data_o=0, out_mode_o=0, count_o=0.
  - in_ready_o=1 once rst is low.
  - Reset asserted mid-stream discards all in-flight beats; none is delivered afterwards.
- Handshakes:
  - Input transfer when in_valid_i & in_ready_o.
  - Output transfer when out_valid_o & out_ready_i.
  - out_valid_o, out_data_o and out_mode_o hold stable while out_valid_o=1 and out_ready_i=0.
- Lane operation: combinational before stage 0, unsigned operands, result WIDTH+1 bits.
  - PASS=0: {1'b0, a}.
  - ADD=1: a+b with carry in the MSB.
  - SUB=2: a-b as (WIDTH+1)-bit two's complement; MSB=1 means borrow.
  - MAX=3: {1'b0, max(a,b)}; on a tie, a is selected.
- Pipeline:
  - DEPTH identical stages; each holds valid, mode and NUM_CH lane results.
  - Stage i loads from upstream when its own ready is high.
  - ready_i = ~valid_i | ready_(i+1); the last stage uses out_ready_i. in_ready_o = ready_0.
  - Bubbles collapse: an empty stage fills even while downstream stalls.
  - Ready is a combinational chain across stages. No combinational path from in_valid_i to out_valid_o.
- Latency and throughput:
  - Exactly DEPTH cycles from input transfer to out_valid_o when unstalled.
  - One beat per cycle sustained.
- Capacity and ordering:
  - With out_ready_i held low, exactly DEPTH beats are accepted, then in_ready_o=0.
  - Full with out_ready_i=1: a simultaneous accept and deliver is allowed; occupancy is unchanged.
  - Beats leave in arrival order with no loss or duplication.
- Counter: count_o increments on each output transfer and saturates at 2^CNT_W-1 (no wrap). Cleared only by rst.
- Out-of-range DEPTH: an elaboration-time assertion fires if DEPTH<1 or DEPTH>8.

Decomposition:
- Package dut_pkg holds:
  - typedef enum logic [1:0] mode_e {PASS, ADD, SUB, MAX}.
  - Function lane_op(mode, a, b) returning WIDTH+1 bits.
  - MAX_DEPTH=8.
- Sub-module dut_pipe_stage: one elastic register slice, parametrised on payload width.
- The top generates DEPTH instances of dut_pipe_stage and instantiates the counter inline.

Test Plan (NUM_CH=2, WIDTH=8, DEPTH=3, CNT_W=16 unless stated):
- Reset: rst=1 for 2 cycles, in_valid_i=1 -> out_valid_o=0, out_data_o=0, count_o=0. in_ready_o=1 in the first cycle after rst falls.
- ADD single beat: a={ch1=5, ch0=200}, b={ch1=7, ch0=100}, out_ready_i=1 -> out_valid_o exactly 3 cycles after transfer. Lane0=9'h12C (300), lane1=9'h00C. out_mode_o=ADD, count_o=1.
- SUB/MAX: a=5, b=7 SUB -> 9'h1FE. a=9, b=9 MAX -> 9'h009. a=0, b=255 MAX -> 9'h0FF.
- Back-pressure: out_ready_i=0, drive 5 beats with a=1..5 -> in_ready_o drops after 3 accepts. Raise out_ready_i -> results 1..5 in order, one per cycle, count_o=5.
- Reset mid-stream: 3 beats in flight, rst=1 for 1 cycle -> out_valid_o=0 next cycle. No stale beat ever appears; count_o=0.
- Saturation (CNT_W=4): 20 back-to-back beats with out_ready_i=1 -> count_o reaches 15 and stays at 15.

Source files
------------

// File: rtl/dut_pkg.sv
// Shared types and the per-lane arithmetic used by the operand pipeline.
package dut_pkg;

  typedef enum logic [1:0] {
    PASS = 2'd0,
    ADD  = 2'd1,
    SUB  = 2'd2,
    MAX  = 2'd3
  } mode_e;

  localparam int MAX_DEPTH  = 8;
  localparam int LANE_MAX_W = 32;

  // Operands arrive zero-extended to LANE_MAX_W; callers keep the low WIDTH+1 bits,
  // which gives the carry for ADD and the (WIDTH+1)-bit two's complement for SUB.
  function automatic logic [LANE_MAX_W:0] lane_op(input mode_e mode,
                                                  input logic [LANE_MAX_W-1:0] a,
                                                  input logic [LANE_MAX_W-1:0] b);
    logic [LANE_MAX_W:0] ax;
    logic [LANE_MAX_W:0] bx;
    logic [LANE_MAX_W:0] res;
    ax = {1'b0, a};
    bx = {1'b0, b};
    case (mode)
      PASS:    res = ax;
      ADD:     res = ax + bx;
      SUB:     res = ax - bx;
      default: res = (a >= b) ? ax : bx;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dut_pipe_stage.sv
// One elastic register slice: loads from upstream whenever the supplied ready is high.
module dut_pipe_stage #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_en,
  input  logic                 up_valid,
  input  logic [PAYLOAD_W-1:0] up_data,
  output logic                 valid,
  output logic [PAYLOAD_W-1:0] data
);

  // Payload is only written on a real beat so a drained slot keeps its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (ld_en) begin
      valid <= up_valid;
      if (up_valid) data <= up_data;
    end
  end

endmodule

// File: rtl/dut_pipe_top.sv
// Multi-lane operand capture: lane operation, DEPTH-stage elastic pipeline, beat counter.
module dut_pipe_top
  import dut_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [1:0]                mode_i,
  input  logic [NUM_CH*WIDTH-1:0]   a_i,
  input  logic [NUM_CH*WIDTH-1:0]   b_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [NUM_CH*(WIDTH+1)-1:0] out_data_o,
  output logic [1:0]                out_mode_o,
  output logic [CNT_W-1:0]          count_o
);

  localparam int LANES_W = NUM_CH * (WIDTH + 1);
  localparam int PAY_W   = 2 + LANES_W;

  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("dut_pipe_top: DEPTH must be within 1..8");
  end
  if (WIDTH > LANE_MAX_W) begin : g_bad_width
    $error("dut_pipe_top: WIDTH exceeds lane_op operand width");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [LANES_W-1:0] lanes_p0;
  logic [PAY_W-1:0]   pay_p0;

  // Stage p0 input: lane results computed combinationally from the offered beat.
  always_comb begin
    lanes_p0 = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      lanes_p0[k*(WIDTH+1) +: WIDTH+1] =
        (WIDTH+1)'(lane_op(mode_e'(mode_i),
                           LANE_MAX_W'(a_i[k*WIDTH +: WIDTH]),
                           LANE_MAX_W'(b_i[k*WIDTH +: WIDTH])));
    end
  end

  assign pay_p0 = {mode_i, lanes_p0};

  logic [DEPTH-1:0] stg_vld;
  logic [DEPTH-1:0] stg_rdy;
  logic [DEPTH-1:0] up_vld;
  logic [PAY_W-1:0] stg_dat [DEPTH];
  logic [PAY_W-1:0] up_dat  [DEPTH];

  // A stage can load if it or any stage downstream of it has a free slot, or the sink drains.
  always_comb begin
    logic acc;
    acc     = out_ready_i;
    stg_rdy = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc        = acc | ~stg_vld[i];
      stg_rdy[i] = acc;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign up_vld[i] = in_valid_i;
      assign up_dat[i] = pay_p0;
    end else begin : g_body
      assign up_vld[i] = stg_vld[i-1];
      assign up_dat[i] = stg_dat[i-1];
    end

    dut_pipe_stage #(
      .PAYLOAD_W(PAY_W)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .ld_en    (stg_rdy[i]),
      .up_valid (up_vld[i]),
      .up_data  (up_dat[i]),
      .valid    (stg_vld[i]),
      .data     (stg_dat[i])
    );
  end

  assign in_ready_o                = stg_rdy[0];
  assign out_valid_o               = stg_vld[DEPTH-1];
  assign {out_mode_o, out_data_o}  = stg_dat[DEPTH-1];

  logic [CNT_W-1:0] cnt_q;

  // Output boundary: delivered-beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (out_valid_o && out_ready_i) begin
      cnt_q <= sat_inc(cnt_q);
    end
  end

  assign count_o = cnt_q;

endmodule

// File: tb/tb_dut_pipe_top.sv
// Directed bench for dut_pipe_top: lane ops, latency, back-pressure, reset flush, saturation.
module tb_dut_pipe_top;
  import dut_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  mode;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_ready;

  logic        in_ready,  in_ready4;
  logic        out_valid, out_valid4;
  logic [17:0] out_data,  out_data4;
  logic [1:0]  out_mode,  out_mode4;
  logic [15:0] count;
  logic [3:0]  count4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dut_pipe_top #(.NUM_CH(2), .WIDTH(8), .DEPTH(3), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .mode_i(mode), .a_i(a), .b_i(b), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_data_o(out_data), .out_mode_o(out_mode),
    .count_o(count)
  );

  dut_pipe_top #(.NUM_CH(2), .WIDTH(8), .DEPTH(3), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready4),
    .mode_i(mode), .a_i(a), .b_i(b), .out_valid_o(out_valid4),
    .out_ready_i(out_ready), .out_data_o(out_data4), .out_mode_o(out_mode4),
    .count_o(count4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [7:0] a0, a1, b0, b1;
    logic [8:0] e0, e1;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_cnt;
    int acc, rcv, first_c, last_c;
    logic take;
    logic stale;

    vecs[0] = '{ADD,  8'd200, 8'd5,   8'd100, 8'd7,   9'h12C, 9'h00C};
    vecs[1] = '{SUB,  8'd5,   8'd7,   8'd7,   8'd5,   9'h1FE, 9'h002};
    vecs[2] = '{MAX,  8'd9,   8'd0,   8'd9,   8'd255, 9'h009, 9'h0FF};
    vecs[3] = '{PASS, 8'hAB,  8'hFF,  8'h11,  8'h00,  9'h0AB, 9'h0FF};
    vecs[4] = '{ADD,  8'hFF,  8'h00,  8'hFF,  8'h00,  9'h1FE, 9'h000};
    vecs[5] = '{SUB,  8'd0,   8'd0,   8'd0,   8'd1,   9'h000, 9'h1FF};
    vecs[6] = '{MAX,  8'd200, 8'd3,   8'd100, 8'd4,   9'h0C8, 9'h004};
    vecs[7] = '{MAX,  8'd4,   8'd128, 8'd3,   8'd128, 9'h004, 9'h080};

    rst = 1'b1; in_valid = 1'b1; mode = ADD; a = 16'h1234; b = 16'h5678; out_ready = 1'b1;
    exp_cnt = 0;

    // Reset held for two cycles with a beat offered.
    repeat (2) begin
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_out_data",  32'(out_data),  32'(0));
      check("rst_out_mode",  32'(out_mode),  32'(0));
      check("rst_count",     32'(count),     32'(0));
      check("rst_out4",      32'({out_valid4, out_data4, out_mode4, count4}), 32'(0));
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("post_rst_in_ready",  32'(in_ready),  32'(1));
    check("post_rst_in_ready4", 32'(in_ready4), 32'(1));

    // Single-beat vectors: latency, lane result, mode, counter.
    for (int i = 0; i < 8; i++) begin
      mode = vecs[i].mode; a = {vecs[i].a1, vecs[i].a0}; b = {vecs[i].b1, vecs[i].b0};
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("v%0d_lat1", i), 32'(out_valid), 32'(0));
      @(negedge clk);
      check($sformatf("v%0d_lat2", i), 32'(out_valid), 32'(0));
      @(negedge clk);
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(1));
      check($sformatf("v%0d_data", i),  32'(out_data),  32'({vecs[i].e1, vecs[i].e0}));
      check($sformatf("v%0d_mode", i),  32'(out_mode),  32'(vecs[i].mode));
      check($sformatf("v%0d_cnt_pre", i), 32'(count), 32'(exp_cnt));
      @(negedge clk);
      exp_cnt++;
      check($sformatf("v%0d_cnt", i), 32'(count), 32'(exp_cnt));
      check($sformatf("v%0d_drained", i), 32'(out_valid), 32'(0));
    end

    // Back-pressure: five beats offered, sink stalled.
    out_ready = 1'b0; mode = PASS; b = 16'h0000; acc = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      a = {8'(acc + 17), 8'(acc + 1)};
      #1; take = in_ready;
      @(negedge clk);
      if (take) acc++;
    end
    in_valid = 1'b1; a = {8'(acc + 17), 8'(acc + 1)};
    #1;
    check("bp_accepts", 32'(acc), 32'(3));
    check("bp_in_ready_low", 32'(in_ready), 32'(0));
    check("bp_hold_valid", 32'(out_valid), 32'(1));
    check("bp_hold_data", 32'(out_data), 32'({1'b0, 8'd17, 1'b0, 8'd1}));
    @(negedge clk);
    check("bp_hold_data2", 32'(out_data), 32'({1'b0, 8'd17, 1'b0, 8'd1}));
    check("bp_hold_mode", 32'(out_mode), 32'(PASS));

    out_ready = 1'b1; rcv = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 30 && rcv < 5; c++) begin
      in_valid = (acc < 5);
      a = {8'(acc + 17), 8'(acc + 1)};
      #1;
      take = in_valid && in_ready;
      if (out_valid) begin
        check($sformatf("bp_order%0d", rcv), 32'(out_data),
              32'({1'b0, 8'(rcv + 17), 1'b0, 8'(rcv + 1)}));
        if (first_c < 0) first_c = c;
        last_c = c;
        rcv++;
      end
      @(negedge clk);
      if (take) acc++;
    end
    in_valid = 1'b0;
    exp_cnt += 5;
    check("bp_received", 32'(rcv), 32'(5));
    check("bp_all_accepted", 32'(acc), 32'(5));
    check("bp_back_to_back", 32'(last_c - first_c), 32'(4));
    check("bp_count", 32'(count), 32'(exp_cnt));
    @(negedge clk);
    check("bp_no_dup", 32'(out_valid), 32'(0));

    // Reset while three beats are in flight.
    out_ready = 1'b0; mode = ADD;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; a = {8'(c + 40), 8'(c + 30)};
      @(negedge clk);
    end
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid), 32'(0));
    check("mid_rst_count", 32'(count), 32'(0));
    rst = 1'b0; out_ready = 1'b1; stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid || out_valid4) stale = 1'b1;
    end
    check("mid_rst_no_stale", 32'(stale), 32'(0));
    check("mid_rst_count_after", 32'(count), 32'(0));

    // Twenty back-to-back beats: 4-bit counter must stick at 15.
    out_ready = 1'b1; mode = PASS; acc = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1; a = {8'(c), 8'(c)};
      #1; if (in_ready) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("sat_accepts", 32'(acc), 32'(20));
    check("sat_count16", 32'(count), 32'(20));
    check("sat_count4", 32'(count4), 32'(15));
    check("sat_drained", 32'(out_valid4), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
